// File: rtl/wb_regfile.sv
// Writeback-stage register file: 32 x 32-bit, two combinational read ports with
// write-through bypass, selected writeback data for forwarding, saturating commit counter.
module wb_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemtoReg,
    input  logic        RegWrite,
    input  logic [31:0] Wb_ReadMemData_in,
    input  logic [31:0] Wb_ALUResult_in,
    input  logic [4:0]  Wb_WriteReg_in,
    input  logic [4:0]  Rs_addr,
    input  logic [4:0]  Rt_addr,
    output logic [31:0] Rs_data,
    output logic [31:0] Rt_data,
    output logic [31:0] Wb_WriteData_out,
    output logic [31:0] Wb_Count_out
);

    logic [31:0] r_regs [0:31];
    logic [31:0] r_count;
    logic [31:0] w_wdata;
    logic        w_commit;

    assign w_wdata          = MemtoReg ? Wb_ReadMemData_in : Wb_ALUResult_in;
    assign w_commit         = RegWrite && (Wb_WriteReg_in != 5'd0);
    assign Wb_WriteData_out = w_wdata;
    assign Wb_Count_out     = r_count;

    // Register array: register 0 is never written, so it stays at its reset value of 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= 32'd0;
            end
        end else if (w_commit) begin
            r_regs[Wb_WriteReg_in] <= w_wdata;
        end else begin
            r_regs[Wb_WriteReg_in] <= r_regs[Wb_WriteReg_in];
        end
    end

    // Commit counter, saturating at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= 32'd0;
        end else if (w_commit && (r_count != 32'hFFFF_FFFF)) begin
            r_count <= r_count + 32'd1;
        end else begin
            r_count <= r_count;
        end
    end

    // Read ports; the bypass stays live during reset because it depends only on inputs.
    always_comb begin
        Rs_data = 32'd0;
        Rt_data = 32'd0;
        if (w_commit && (Rs_addr == Wb_WriteReg_in)) begin
            Rs_data = w_wdata;
        end else if (rst) begin
            Rs_data = 32'd0;
        end else begin
            Rs_data = r_regs[Rs_addr];
        end
        if (w_commit && (Rt_addr == Wb_WriteReg_in)) begin
            Rt_data = w_wdata;
        end else if (rst) begin
            Rt_data = 32'd0;
        end else begin
            Rt_data = r_regs[Rt_addr];
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed vector table, reset/saturation
// sequences, and randomized traffic against an array-based reference model.
module tb_wb_regfile;

    logic        clk;
    logic        rst;
    logic        MemtoReg;
    logic        RegWrite;
    logic [31:0] Wb_ReadMemData_in;
    logic [31:0] Wb_ALUResult_in;
    logic [4:0]  Wb_WriteReg_in;
    logic [4:0]  Rs_addr;
    logic [4:0]  Rt_addr;
    logic [31:0] Rs_data;
    logic [31:0] Rt_data;
    logic [31:0] Wb_WriteData_out;
    logic [31:0] Wb_Count_out;

    int checks;
    int failures;

    logic [31:0] m_regs [0:31];
    longint      m_count;

    typedef struct {
        logic        rw;
        logic        m2r;
        logic [31:0] mem;
        logic [31:0] alu;
        logic [4:0]  wr;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [31:0] exp_rs;
        logic [31:0] exp_rt;
        logic [31:0] exp_wd;
        logic [31:0] exp_cnt;
    } vec_t;

    vec_t vecs [8];

    wb_regfile dut (
        .clk               (clk),
        .rst               (rst),
        .MemtoReg          (MemtoReg),
        .RegWrite          (RegWrite),
        .Wb_ReadMemData_in (Wb_ReadMemData_in),
        .Wb_ALUResult_in   (Wb_ALUResult_in),
        .Wb_WriteReg_in    (Wb_WriteReg_in),
        .Rs_addr           (Rs_addr),
        .Rt_addr           (Rt_addr),
        .Rs_data           (Rs_data),
        .Rt_data           (Rt_data),
        .Wb_WriteData_out  (Wb_WriteData_out),
        .Wb_Count_out      (Wb_Count_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rw, input logic m2r, input logic [31:0] mem,
                         input logic [31:0] alu, input logic [4:0] wr,
                         input logic [4:0] rs, input logic [4:0] rt);
        RegWrite          = rw;
        MemtoReg          = m2r;
        Wb_ReadMemData_in = mem;
        Wb_ALUResult_in   = alu;
        Wb_WriteReg_in    = wr;
        Rs_addr           = rs;
        Rt_addr           = rt;
    endtask

    function automatic logic [31:0] model_wd();
        return MemtoReg ? Wb_ReadMemData_in : Wb_ALUResult_in;
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] a);
        if (RegWrite && Wb_WriteReg_in != 5'd0 && a == Wb_WriteReg_in) return model_wd();
        if (rst) return 32'd0;
        return m_regs[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_count = 0;
    endtask

    // Apply the architectural effect of the current inputs at a clock edge.
    task automatic model_edge();
        if (rst) begin
            model_reset();
        end else if (RegWrite && Wb_WriteReg_in != 5'd0) begin
            m_regs[Wb_WriteReg_in] = model_wd();
            m_count = (m_count + 1 > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_count + 1;
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, "_rs"}, Rs_data, model_read(Rs_addr));
        check({tag, "_rt"}, Rt_data, model_read(Rt_addr));
        check({tag, "_wd"}, Wb_WriteData_out, model_wd());
        check({tag, "_cnt"}, Wb_Count_out, m_count[31:0]);
    endtask

    task automatic clock_step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        model_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);

        vecs[0] = '{1'b1, 1'b0, 32'h0, 32'h0000_1234, 5'd5, 5'd5, 5'd5, 32'h0000_1234, 32'h0000_1234, 32'h0000_1234, 32'd1};
        vecs[1] = '{1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd5, 32'h0000_1234, 32'h0000_1234, 32'h0, 32'd1};
        vecs[2] = '{1'b1, 1'b1, 32'hDEAD_BEEF, 32'h1, 5'd9, 5'd9, 5'd5, 32'hDEAD_BEEF, 32'h0000_1234, 32'hDEAD_BEEF, 32'd2};
        vecs[3] = '{1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd9, 5'd9, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0, 32'd2};
        vecs[4] = '{1'b1, 1'b0, 32'h0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'd2};
        vecs[5] = '{1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'd2};
        vecs[6] = '{1'b0, 1'b0, 32'h0, 32'h55, 5'd3, 5'd3, 5'd3, 32'h0, 32'h0, 32'h55, 32'd2};
        vecs[7] = '{1'b0, 1'b0, 32'h0, 32'h0, 5'd3, 5'd3, 5'd9, 32'h0, 32'hDEAD_BEEF, 32'h0, 32'd2};

        // Reset state
        @(negedge clk);
        #1;
        check("reset_rs0", Rs_data, 32'd0);
        check("reset_cnt", Wb_Count_out, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed vector table: pre-edge reads/bypass, post-edge count
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].rw, vecs[i].m2r, vecs[i].mem, vecs[i].alu, vecs[i].wr, vecs[i].rs, vecs[i].rt);
            #1;
            check($sformatf("vec%0d_rs", i), Rs_data, vecs[i].exp_rs);
            check($sformatf("vec%0d_rt", i), Rt_data, vecs[i].exp_rt);
            check($sformatf("vec%0d_wd", i), Wb_WriteData_out, vecs[i].exp_wd);
            @(posedge clk);
            model_edge();
            #1;
            check($sformatf("vec%0d_cnt", i), Wb_Count_out, vecs[i].exp_cnt);
            @(negedge clk);
        end

        // Asynchronous reset mid-cycle wipes a freshly written register
        drive(1'b1, 1'b0, 32'h0, 32'hA5A5_A5A5, 5'd7, 5'd7, 5'd7);
        clock_step();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd7, 5'd7);
        #1;
        check("pre_rst_r7", Rs_data, 32'hA5A5_A5A5);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_r7", Rs_data, 32'd0);
        check("async_rst_cnt", Wb_Count_out, 32'd0);
        model_reset();
        // Bypass stays live during reset, but the write itself is lost
        drive(1'b1, 1'b0, 32'h0, 32'h77, 5'd4, 5'd4, 5'd7);
        #1;
        check("rst_bypass_rs", Rs_data, 32'h77);
        check("rst_bypass_rt", Rt_data, 32'd0);
        clock_step();
        rst = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd4, 5'd4);
        #1;
        check("rst_write_lost", Rs_data, 32'd0);
        check("rst_write_cnt", Wb_Count_out, 32'd0);
        // First commit lands on the first edge after reset release
        drive(1'b1, 1'b0, 32'h0, 32'h88, 5'd4, 5'd1, 5'd1);
        clock_step();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd4, 5'd4);
        #1;
        check("first_commit_r4", Rs_data, 32'h88);
        check("first_commit_cnt", Wb_Count_out, 32'd1);

        // Randomized traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            logic [4:0] wr;
            wr = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom, wr,
                  ($urandom_range(0, 2) == 0) ? wr : 5'($urandom_range(0, 31)),
                  ($urandom_range(0, 2) == 0) ? wr : 5'($urandom_range(0, 31)));
            if ($urandom_range(0, 7) == 0) Rt_addr = Rs_addr;
            #1;
            check_model($sformatf("rand%0d", n));
            clock_step();
        end

        // Saturation: preload the counter near the top, then commit three times
        force dut.r_count = 32'hFFFF_FFFE;
        #1;
        release dut.r_count;
        m_count = 64'hFFFF_FFFE;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b0, 32'h0, 32'h100 + k, 5'd10, 5'd10, 5'd0);
            clock_step();
            #1;
            check($sformatf("sat%0d_cnt", k), Wb_Count_out, 32'hFFFF_FFFF);
        end
        check("sat_model_cnt", Wb_Count_out, m_count[31:0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 The block SHALL have no parameters; register count fixed at 32, data width fixed at 32.
REQ-002 The block SHALL provide port clk  input  1  single clock; all state updates on posedge.
REQ-003 The block SHALL provide port rst  input  1  reset; asynchronous, active-high.
REQ-004 The block SHALL provide port MemtoReg  input  1  writeback source select; 1 = memory data, 0 = ALU result.
REQ-005 The block SHALL provide port RegWrite  input  1  writeback enable.
REQ-006 The block SHALL provide port Wb_ReadMemData_in  input  32  loaded memory data from the MEM/WB stage.
REQ-007 The block SHALL provide port Wb_ALUResult_in  input  32  ALU result from the MEM/WB stage.
REQ-008 The block SHALL provide port Wb_WriteReg_in  input  5  destination register number.
REQ-009 The block SHALL provide port Rs_addr  input  5  read port A address.
REQ-010 The block SHALL provide port Rt_addr  input  5  read port B address.
REQ-011 The block SHALL provide port Rs_data  output  32  read port A data.
REQ-012 The block SHALL provide port Rt_data  output  32  read port B data.
REQ-013 The block SHALL provide port Wb_WriteData_out  output  32  selected writeback data, for forwarding.
REQ-014 The block SHALL provide port Wb_Count_out  output  32  count of committed register writes.

Function
REQ-015 Wb_WriteData_out SHALL be combinational: MemtoReg ? Wb_ReadMemData_in : Wb_ALUResult_in, independent of RegWrite.
REQ-016 Commit condition: RegWrite==1 and Wb_WriteReg_in!=0.
REQ-017 On posedge clk with the commit condition true, register[Wb_WriteReg_in] SHALL take Wb_WriteData_out; no other register changes.
REQ-018 Writes to register 0 SHALL be discarded; register 0 SHALL always read 0.
REQ-019 Reads SHALL be combinational, zero latency: Rs_data = register[Rs_addr], Rt_data = register[Rt_addr].
REQ-020 Write-through bypass: with the commit condition true and Rs_addr==Wb_WriteReg_in, Rs_data SHALL equal Wb_WriteData_out in the same cycle; the same rule applies independently to Rt.
REQ-021 Bypass SHALL never apply when the address is 0 or RegWrite==0.
REQ-022 Both read ports SHALL return identical data when Rs_addr==Rt_addr, including under bypass.
REQ-023 Wb_Count_out SHALL increment by 1 on each posedge where the commit condition is true.
REQ-024 Wb_Count_out SHALL saturate at 32'hFFFFFFFF; it SHALL not wrap to 0.
REQ-025 X or unknown data on the data inputs with RegWrite==0 SHALL not alter any stored state.

Reset
REQ-026 While rst==1, all 32 registers and Wb_Count_out SHALL be 0 immediately, without waiting for clk.
REQ-027 rst SHALL override a simultaneous commit; a write coinciding with reset assertion SHALL be lost.
REQ-028 During reset, Rs_data and Rt_data SHALL read 0, except under bypass per REQ-020, which stays combinational.
REQ-029 The first commit SHALL occur on the first posedge clk after rst deasserts.

Verification
REQ-030 Reset, then RegWrite=1, MemtoReg=0, ALU=32'h0000_1234, WriteReg=5, one clock -> reg5 reads 32'h0000_1234 on both ports; Wb_Count_out=1.
REQ-031 RegWrite=1, MemtoReg=1, Mem=32'hDEAD_BEEF, ALU=32'h1, WriteReg=9, Rs_addr=9 before the edge -> Rs_data=32'hDEAD_BEEF pre-edge (bypass) and post-edge (stored).
REQ-032 RegWrite=1, WriteReg=0, ALU=32'hFFFF_FFFF, clock -> Rs_addr=0 reads 0 before and after; Wb_Count_out unchanged.
REQ-033 RegWrite=0, WriteReg=3, ALU=32'h55, clock -> reg3 unchanged; Wb_Count_out unchanged; Wb_WriteData_out=32'h55.
REQ-034 Write reg7=32'hA5A5_A5A5, then assert rst asynchronously mid-cycle -> Rs_data at Rs_addr=7 reads 0 before the next clk edge; Wb_Count_out=0.
REQ-035 Force the counter to 32'hFFFF_FFFE, commit 3 writes -> Wb_Count_out reads 32'hFFFF_FFFF and holds.
